syndrome_stream_packer: RTL and testbench
=========================================

# syndrome_stream_packer

Host-side framing stage that sits directly upstream of the decoder's input FIFO and downstream of its output FIFO. It collects one full syndrome volume, one measurement round per handshake, and serialises it into the decoder's byte protocol: a single START_DECODING_MSG after reset, then for each volume MEASUREMENT_DATA_HEADER followed by the payload bytes. It then consumes the decoder's fixed 3-byte result message and presents the iteration and cycle counts as one parallel result.

## Interface

Parameters:
- GRID_WIDTH_X, 8: stabiliser grid width in X.
- GRID_WIDTH_Z, 4: stabiliser grid width in Z.
- GRID_WIDTH_U, 7: measurement rounds per volume.
- Derived values:
  - BYTES_PER_ROUND = ceil(GRID_WIDTH_X*GRID_WIDTH_Z/8).
  - ALIGNED_PU_PER_ROUND = 8*BYTES_PER_ROUND.
  - PAYLOAD_BYTES = BYTES_PER_ROUND*GRID_WIDTH_U.
- START_DECODING_MSG and MEASUREMENT_DATA_HEADER are taken from the shared parameters include.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- round_data  in  ALIGNED_PU_PER_ROUND  one measurement round; bit i*GRID_WIDTH_Z+j is stabiliser (i,j).
- round_valid  in  1  round_data valid.
- round_ready  out  1  round accepted on valid&ready.
- out_data  out  8  byte toward the decoder input FIFO.
- out_valid  out  1  out_data valid.
- out_ready  in  1  FIFO accepts the byte.
- resp_data  in  8  byte from the decoder output FIFO.
- resp_valid  in  1  resp_data valid.
- resp_ready  out  1  byte consumed on valid&ready.
- result_iterations  out  8  iteration count of the last completed volume.
- result_cycles  out  16  cycle count of the last completed volume.
- result_valid  out  1  single-cycle pulse when the result fields update.
- frame_count  out  16  completed volumes; wraps modulo 2^16.

## Operation

The block is a state machine with five states: START, COLLECT, HEADER, PAYLOAD, RESP.

- **START:** drive out_valid=1 and out_data=START_DECODING_MSG. On out handshake, go to COLLECT. This state is entered only after reset.
- **COLLECT:** drive round_ready=1. On each round handshake, store round_data into buffer slot round_cnt and increment round_cnt. On the handshake where round_cnt==GRID_WIDTH_U-1, clear round_cnt and go to HEADER.
  - Bits at index GRID_WIDTH_X*GRID_WIDTH_Z and above are forced to 0 when stored.
- **HEADER:** drive out_valid=1 and out_data=MEASUREMENT_DATA_HEADER. On handshake, clear byte_cnt and go to PAYLOAD.
- **PAYLOAD:** drive out_valid=1 and out_data=buffer[byte_cnt*8 +: 8]. Round 0 is sent first, least-significant byte first. On handshake, increment byte_cnt. On the handshake where byte_cnt==PAYLOAD_BYTES-1, clear resp_cnt and go to RESP.
- **RESP:** drive resp_ready=1. Response bytes, in order:
  - byte 0 → iterations.
  - byte 1 → cycles[15:8].
  - byte 2 → cycles[7:0].
  - On the third handshake: update the result registers, pulse result_valid, increment frame_count, and go to COLLECT.

Further rules:
- round_ready is 1 only in COLLECT.
- resp_ready is 1 only in RESP. Response bytes arriving in any other state are left in the FIFO and are neither dropped nor parsed.
- out_valid is 1 only in START, HEADER and PAYLOAD. out_valid and out_data never depend on out_ready. Once out_valid is raised, out_data stays stable until the handshake.
- Exactly one volume is outstanding at a time; no new round is accepted until its result has been received.

## Timing

- Reset values:
  - state=START, so out_valid=1 with out_data=START_DECODING_MSG in the first cycle after reset deasserts.
  - round_ready=0, resp_ready=0, result_valid=0, result_iterations=0, result_cycles=0, frame_count=0.
  - Internal counters are cleared to 0.
- Reset asserted mid-operation (any state) discards the buffer and any partial response, and START is sent again.
- Throughput is one byte per cycle when out_ready is held at 1. Stalls on out_ready, round_valid or resp_valid of any length are tolerated.
- HEADER out_valid rises the cycle after the last round handshake.
- With out_ready=1 throughout, the frame occupies exactly 1+PAYLOAD_BYTES out cycles.
- result_valid is high for exactly one cycle: the cycle after the third resp handshake. Result fields hold their value until the next pulse.
- frame_count wraps from 0xFFFF to 0x0000.

## Test plan

1. Reset, out_ready=1 → out_data=START_DECODING_MSG in the first cycle; round_ready=0 during that cycle and 1 in the next.
2. Defaults (8,4,7), rounds k=0..6 with round_data=32'h01020304+k → header, then 28 payload bytes 04,03,02,01, 05,03,02,01, ... in order. round_ready stays 0 until the response.
3. Same frame with out_ready toggled every other cycle → identical byte sequence. out_data is held whenever out_valid=1 and out_ready=0.
4. Response bytes 0x05, 0x01, 0x2C → result_iterations=5, result_cycles=300, result_valid pulses once, frame_count=1, round_ready=1 the next cycle.
5. resp_valid=1 during PAYLOAD → resp_ready=0 and the byte is not parsed. After the frame completes, the byte is consumed as the iteration count.
6. Reset asserted halfway through PAYLOAD → START_DECODING_MSG is resent, frame_count=0, and the next frame's payload contains only the new rounds.

Source files
------------

// File: rtl/syndrome_stream_packer.sv
// syndrome_stream_packer
// Collects one syndrome volume (GRID_WIDTH_U rounds) and frames it for the decoder:
// START_DECODING_MSG once after reset, then per volume MEASUREMENT_DATA_HEADER followed
// by the payload bytes. It then parses the decoder's 3-byte result message.
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   round_data/valid/ready : one measurement round per handshake (upstream)
//   out_data/valid/ready   : byte stream toward the decoder input FIFO
//   resp_data/valid/ready  : byte stream from the decoder output FIFO
//   result_iterations/cycles/valid : parsed result of the last volume, valid pulses once
//   frame_count         : completed volumes, wraps modulo 2^16
module syndrome_stream_packer #(
  parameter int unsigned GRID_WIDTH_X = 8,
  parameter int unsigned GRID_WIDTH_Z = 4,
  parameter int unsigned GRID_WIDTH_U = 7,
  // Protocol codes shared with the decoder; defaults match its parameter set.
  parameter logic [7:0] START_DECODING_MSG      = 8'h01,
  parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [8*((GRID_WIDTH_X*GRID_WIDTH_Z+7)/8)-1:0]       round_data,
  input  logic                                                 round_valid,
  output logic                                                 round_ready,
  output logic [7:0]                                           out_data,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  input  logic [7:0]                                           resp_data,
  input  logic                                                 resp_valid,
  output logic                                                 resp_ready,
  output logic [7:0]                                           result_iterations,
  output logic [15:0]                                          result_cycles,
  output logic                                                 result_valid,
  output logic [15:0]                                          frame_count
);

  localparam int unsigned STAB_BITS       = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int unsigned BYTES_PER_ROUND = (STAB_BITS + 7) / 8;
  localparam int unsigned ALIGNED_BITS    = 8 * BYTES_PER_ROUND;
  localparam int unsigned PAYLOAD_BYTES   = BYTES_PER_ROUND * GRID_WIDTH_U;
  localparam int unsigned BCW             = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int unsigned RCW             = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;

  // Keeps only real stabiliser bits; alignment padding is stored as zero.
  localparam logic [ALIGNED_BITS-1:0] VALID_MASK =
    {ALIGNED_BITS{1'b1}} >> (ALIGNED_BITS - STAB_BITS);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_COLLECT = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [RCW-1:0]       round_cnt;
  logic [BCW-1:0]       byte_cnt;
  logic [1:0]           resp_cnt;
  logic [7:0]           iter_tmp;
  logic [7:0]           cyc_hi_tmp;
  logic [7:0]           buf_bytes [PAYLOAD_BYTES];
  logic [ALIGNED_BITS-1:0] round_masked;

  logic out_fire;
  logic round_fire;
  logic resp_fire;
  logic last_round;
  logic last_byte;
  logic last_resp;

  assign out_fire   = out_valid & out_ready;
  assign round_fire = round_valid & round_ready;
  assign resp_fire  = resp_valid & resp_ready;
  assign last_round = (round_cnt == RCW'(GRID_WIDTH_U - 1));
  assign last_byte  = (byte_cnt == BCW'(PAYLOAD_BYTES - 1));
  assign last_resp  = (resp_cnt == 2'd2);
  assign round_masked = round_data & VALID_MASK;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_START;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:   if (out_fire) state_d = S_COLLECT;
      S_COLLECT: if (round_fire && last_round) state_d = S_HEADER;
      S_HEADER:  if (out_fire) state_d = S_PAYLOAD;
      S_PAYLOAD: if (out_fire && last_byte) state_d = S_RESP;
      S_RESP:    if (resp_fire && last_resp) state_d = S_COLLECT;
      default:   state_d = S_START;
    endcase
  end

  // Output decode; depends on state and stored data only, never on out_ready.
  always_comb begin
    round_ready = 1'b0;
    resp_ready  = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    case (state_q)
      S_START: begin
        out_valid = 1'b1;
        out_data  = START_DECODING_MSG;
      end
      S_COLLECT: round_ready = 1'b1;
      S_HEADER: begin
        out_valid = 1'b1;
        out_data  = MEASUREMENT_DATA_HEADER;
      end
      S_PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = buf_bytes[byte_cnt];
      end
      S_RESP:  resp_ready = 1'b1;
      default: ;
    endcase
  end

  // Counters, response parsing and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      round_cnt         <= '0;
      byte_cnt          <= '0;
      resp_cnt          <= '0;
      iter_tmp          <= '0;
      cyc_hi_tmp        <= '0;
      result_iterations <= '0;
      result_cycles     <= '0;
      result_valid      <= 1'b0;
      frame_count       <= '0;
    end else begin
      result_valid <= 1'b0;

      if (round_fire) begin
        if (last_round) round_cnt <= '0;
        else            round_cnt <= round_cnt + RCW'(1);
      end

      if (state_q == S_HEADER && out_fire) byte_cnt <= '0;
      if (state_q == S_PAYLOAD && out_fire) begin
        if (last_byte) begin
          byte_cnt <= '0;
          resp_cnt <= '0;
        end else begin
          byte_cnt <= byte_cnt + BCW'(1);
        end
      end

      if (resp_fire) begin
        case (resp_cnt)
          2'd0:    iter_tmp   <= resp_data;
          2'd1:    cyc_hi_tmp <= resp_data;
          default: begin
            result_iterations <= iter_tmp;
            result_cycles     <= {cyc_hi_tmp, resp_data};
            result_valid      <= 1'b1;
            frame_count       <= frame_count + 16'd1;
          end
        endcase
        resp_cnt <= last_resp ? 2'd0 : resp_cnt + 2'd1;
      end
    end
  end

  // Volume buffer; every slot is rewritten before it is sent, so no reset is needed.
  always_ff @(posedge clk) begin
    if (round_fire) begin
      for (int unsigned b = 0; b < BYTES_PER_ROUND; b++) begin
        buf_bytes[BCW'(32'(round_cnt) * BYTES_PER_ROUND + b)] <= round_masked[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_syndrome_stream_packer.sv
// tb_syndrome_stream_packer
// Directed/randomized bench for syndrome_stream_packer with default grid (8,4,7).
// Expected byte streams come from a queue model built from the framing rules.
module tb_syndrome_stream_packer;

  localparam int unsigned GX   = 8;
  localparam int unsigned GZ   = 4;
  localparam int unsigned GU   = 7;
  localparam int unsigned BPR  = (GX * GZ + 7) / 8;
  localparam int unsigned PB   = BPR * GU;
  localparam logic [7:0] START_MSG = 8'h01;
  localparam logic [7:0] HDR_MSG   = 8'h02;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] round_data;
  logic        round_valid;
  logic        round_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  result_iterations;
  logic [15:0] result_cycles;
  logic        result_valid;
  logic [15:0] frame_count;

  syndrome_stream_packer dut (
    .clk               (clk),
    .reset             (reset),
    .round_data        (round_data),
    .round_valid       (round_valid),
    .round_ready       (round_ready),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .resp_data         (resp_data),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .result_iterations (result_iterations),
    .result_cycles     (result_cycles),
    .result_valid      (result_valid),
    .frame_count       (frame_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] rnd [GU];
  logic [7:0]  exp_q [$];
  int          exp_fc = 0;
  int          cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference frame: header then each round's stabiliser bits, LSB byte first.
  task automatic build_frame();
    logic [31:0] mask;
    mask = 32'((64'd1 << (GX * GZ)) - 64'd1);
    exp_q.delete();
    exp_q.push_back(HDR_MSG);
    for (int k = 0; k < int'(GU); k++)
      for (int b = 0; b < int'(BPR); b++)
        exp_q.push_back(8'((rnd[k] & mask) >> (8 * b)));
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    round_valid = 1'b0;
    round_data  = '0;
    out_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_data   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_rounds(input bit gaps);
    int n;
    for (int k = 0; k < int'(GU); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (k == 0) chk("collect_out_valid", 32'(out_valid), 32'd0);
      round_data  = rnd[k];
      round_valid = 1'b1;
      n = 0;
      while (!round_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("round_wait", 32'(round_ready), 32'd1);
      @(negedge clk);
      round_valid = 1'b0;
    end
  endtask

  // Consumes n bytes of exp_q; mode 0 always ready, 1 toggled, 2 random.
  task automatic recv(input int n, input int mode, output int cycles);
    int idx = 0;
    int c = 0;
    bit rdy;
    bit tog = 1'b0;
    while (idx < n && c < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       begin rdy = tog; tog = ~tog; end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (out_valid) begin
        chk("out_data", 32'(out_data), 32'(exp_q[idx]));
        chk("resp_ready_busy", 32'(resp_ready), 32'd0);
      end
      out_ready = rdy;
      if (out_valid && rdy) idx++;
      c++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("out_count", 32'(idx), 32'(n));
    cycles = c;
  endtask

  task automatic send_resp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    int n;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int i = 0; i < 3; i++) begin
      resp_data  = bs[i];
      resp_valid = 1'b1;
      n = 0;
      while (!resp_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("resp_wait", 32'(resp_ready), 32'd1);
      if (i == 2) chk("result_valid_early", 32'(result_valid), 32'd0);
      @(negedge clk);
      resp_valid = 1'b0;
      if (i < 2) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    exp_fc = (exp_fc + 1) % 65536;
    chk("result_valid", 32'(result_valid), 32'd1);
    chk("result_iterations", 32'(result_iterations), 32'(b0));
    chk("result_cycles", 32'(result_cycles), 32'({b1, b2}));
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
    chk("round_ready_after", 32'(round_ready), 32'd1);
    @(negedge clk);
    chk("result_valid_pulse", 32'(result_valid), 32'd0);
    chk("result_hold", 32'(result_cycles), 32'({b1, b2}));
  endtask

  task automatic check_start();
    chk("start_out_valid", 32'(out_valid), 32'd1);
    chk("start_out_data", 32'(out_data), 32'(START_MSG));
    chk("start_round_ready", 32'(round_ready), 32'd0);
    chk("start_resp_ready", 32'(resp_ready), 32'd0);
    chk("rst_result_valid", 32'(result_valid), 32'd0);
    chk("rst_iterations", 32'(result_iterations), 32'd0);
    chk("rst_cycles", 32'(result_cycles), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    exp_q.push_back(START_MSG);
    recv(1, 0, cyc);
    chk("start_cycles", 32'(cyc), 32'd1);
    chk("collect_round_ready", 32'(round_ready), 32'd1);
  endtask

  task automatic finish_frame_checks();
    chk("frame_end_out_valid", 32'(out_valid), 32'd0);
    chk("frame_end_resp_ready", 32'(resp_ready), 32'd1);
    round_valid = 1'b1;
    round_data  = 32'hDEAD_BEEF;
    repeat (3) begin
      chk("no_round_while_busy", 32'(round_ready), 32'd0);
      @(negedge clk);
    end
    round_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] r0, r1, r2;

    // Reset and START message
    do_reset();
    check_start();

    // Incrementing-pattern frame with out_ready held high
    for (int k = 0; k < int'(GU); k++) rnd[k] = 32'h0102_0304 + 32'(k);
    build_frame();
    push_rounds(1'b0);
    chk("header_rise", 32'(out_valid), 32'd1);
    recv(1 + int'(PB), 0, cyc);
    chk("frame_cycles", 32'(cyc), 32'(1 + PB));
    finish_frame_checks();
    send_resp(8'h05, 8'h01, 8'h2C);
    chk("iter_5", 32'(result_iterations), 32'd5);
    chk("cycles_300", 32'(result_cycles), 32'd300);

    // Same frame with toggled out_ready
    push_rounds(1'b0);
    recv(1 + int'(PB), 1, cyc);
    finish_frame_checks();
    send_resp(8'($urandom), 8'($urandom), 8'($urandom));

    // Response byte waiting during PAYLOAD must not be consumed early
    for (int k = 0; k < int'(GU); k++) rnd[k] = $urandom;
    build_frame();
    push_rounds(1'b1);
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
    resp_data  = r0;
    resp_valid = 1'b1;
    recv(1 + int'(PB), 2, cyc);
    chk("early_resp_held", 32'(frame_count), 32'(exp_fc));
    send_resp(r0, r1, r2);

    // Reset halfway through PAYLOAD
    for (int k = 0; k < int'(GU); k++) rnd[k] = $urandom;
    build_frame();
    push_rounds(1'b1);
    recv(1 + int'(PB) / 2, 2, cyc);
    do_reset();
    exp_fc = 0;
    check_start();
    for (int k = 0; k < int'(GU); k++) rnd[k] = $urandom;
    build_frame();
    push_rounds(1'b1);
    recv(1 + int'(PB), 2, cyc);
    finish_frame_checks();
    send_resp(8'($urandom), 8'($urandom), 8'($urandom));

    // A few more random frames
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < int'(GU); k++) rnd[k] = $urandom;
      build_frame();
      push_rounds(1'b1);
      recv(1 + int'(PB), 2, cyc);
      finish_frame_checks();
      send_resp(8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
